// File: rtl/request_button_if.sv
// Signal bundle between one push-button front end (master) and the
// traffic-controller request/service logic (slave).
interface request_button_if #(
  parameter int COUNT_WIDTH = 8
);
  logic                   not_button;
  logic                   service_ack;
  logic                   button_pressed;
  logic                   press_pulse;
  logic                   request_pending;
  logic [COUNT_WIDTH-1:0] press_count;

  // Handshake: the master raises request_pending on an accepted press and
  // holds it; the slave answers with a one-cycle service_ack, which clears
  // the request unless a new press is accepted on that same edge.
  modport master (
    input  not_button,
    input  service_ack,
    output button_pressed,
    output press_pulse,
    output request_pending,
    output press_count
  );

  modport slave (
    output not_button,
    output service_ack,
    input  button_pressed,
    input  press_pulse,
    input  request_pending,
    input  press_count
  );
endinterface

// File: rtl/request_button_interface.sv
// Synchronizes and debounces an active-low KEY, emits a one-cycle press
// pulse, latches a request until service_ack, and counts accepted presses.
module request_button_interface #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int COUNT_WIDTH     = 8
) (
  input  logic              clk,
  input  logic              reset,
  request_button_if.master  bus
);

  localparam logic [7:0]             DB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

  logic                   s1_q, s2_q;
  logic                   db_q, db_d;
  logic [7:0]             db_cnt_q, db_cnt_d;
  logic                   pulse_q, pulse_d;
  logic                   pend_q, pend_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   raw_pressed;
  logic                   press_event;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q     <= 1'b1;
      s2_q     <= 1'b1;
      db_q     <= 1'b0;
      db_cnt_q <= '0;
      pulse_q  <= 1'b0;
      pend_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      s1_q     <= bus.not_button;
      s2_q     <= s1_q;
      db_q     <= db_d;
      db_cnt_q <= db_cnt_d;
      pulse_q  <= pulse_d;
      pend_q   <= pend_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    raw_pressed = ~s2_q;
    db_d        = db_q;
    db_cnt_d    = '0;
    press_event = 1'b0;

    // A mismatch must persist DEBOUNCE_CYCLES edges; any shorter run is dropped.
    if (raw_pressed != db_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_d        = raw_pressed;
        press_event = raw_pressed;
      end else begin
        db_cnt_d = db_cnt_q + 8'd1;
      end
    end

    pulse_d = press_event;

    // A press on the same edge as service_ack wins so the new request survives.
    if (press_event)          pend_d = 1'b1;
    else if (bus.service_ack) pend_d = 1'b0;
    else                      pend_d = pend_q;

    if (press_event && (count_q != CNT_MAX)) count_d = count_q + 1'b1;
    else                                     count_d = count_q;
  end

  assign bus.button_pressed  = db_q;
  assign bus.press_pulse     = pulse_q;
  assign bus.request_pending = pend_q;
  assign bus.press_count     = count_q;

endmodule
